// File: rtl/md_iter_unit.sv
// md_iter_unit: EX-stage multiply/divide unit with HI/LO and a busy counter.
// Define MD_MADD_EN to enable the MADD/MSUB accumulate ops (op 110/111).
module md_iter_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic             kill,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   output logic             busy,
   output logic             stall_req,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                         MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int W2   = 2 * WIDTH;

   localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] ONE    = CW'(1);

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101,
      OP_MADD  = 3'b110,
      OP_MSUB  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ACC_SET = 2'd0,
      ACC_ADD = 2'd1,
      ACC_SUB = 2'd2
   } acc_e;

   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [W2-1:0]    pend_q, pend_d;
   acc_e             acc_q, acc_d;

   op_e              op_c;
   logic             is_mul;
   logic             is_div;
   logic             is_mac;

   assign op_c   = op_e'(op);
   assign is_mul = (op_c == OP_MULT) | (op_c == OP_MULTU);
   assign is_div = (op_c == OP_DIV) | (op_c == OP_DIVU);
`ifdef MD_MADD_EN
   assign is_mac = (op_c == OP_MADD) | (op_c == OP_MSUB);
`else
   assign is_mac = 1'b0;
`endif

   assign busy      = (cnt_q != '0);
   assign stall_req = busy | (start & (is_mul | is_div | is_mac));
   assign hi        = hi_q;
   assign lo        = lo_q;

   // Products: sign- or zero-extend to 2*WIDTH, keep the low 2*WIDTH bits
   logic [W2-1:0] a_sx, b_sx;
   logic [W2-1:0] a_zx, b_zx;
   logic [W2-1:0] prod_s, prod_u;

   assign a_sx   = {{WIDTH{rs[WIDTH-1]}}, rs};
   assign b_sx   = {{WIDTH{rt[WIDTH-1]}}, rt};
   assign a_zx   = {{WIDTH{1'b0}}, rs};
   assign b_zx   = {{WIDTH{1'b0}}, rt};
   assign prod_s = a_sx * b_sx;
   assign prod_u = a_zx * b_zx;

   // One unsigned divider on magnitudes serves both DIV and DIVU
   logic             sgn;
   logic             a_neg, b_neg;
   logic             div0;
   logic [WIDTH-1:0] a_mag, b_mag, b_use;
   logic [WIDTH-1:0] q_mag, r_mag;
   logic [WIDTH-1:0] quo, rem;
   logic [W2-1:0]    div_res;

   assign sgn     = (op_c == OP_DIV);
   assign a_neg   = sgn & rs[WIDTH-1];
   assign b_neg   = sgn & rt[WIDTH-1];
   assign a_mag   = a_neg ? (-rs) : rs;
   assign b_mag   = b_neg ? (-rt) : rt;
   assign div0    = (rt == '0);
   assign b_use   = div0 ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
   assign q_mag   = a_mag / b_use;
   assign r_mag   = a_mag % b_use;
   assign quo     = (a_neg ^ b_neg) ? (-q_mag) : q_mag;
   assign rem     = a_neg ? (-r_mag) : r_mag;
   assign div_res = div0 ? {rs, {WIDTH{1'b1}}} : {rem, quo};

   logic [W2-1:0] hilo;
   logic [W2-1:0] commit;

   assign hilo = {hi_q, lo_q};

   always_comb begin
      commit = pend_q;
      case (acc_q)
         ACC_ADD: commit = hilo + pend_q;
         ACC_SUB: commit = hilo - pend_q;
         default: commit = pend_q;
      endcase
   end

   // Kill beats completion and start; a busy unit ignores start
   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      cnt_d  = cnt_q;
      pend_d = pend_q;
      acc_d  = acc_q;
      if (kill) begin
         cnt_d = '0;
      end else if (busy) begin
         cnt_d = cnt_q - ONE;
         if (cnt_q == ONE) begin
            {hi_d, lo_d} = commit;
         end
      end else if (start) begin
         case (op_c)
            OP_MULT: begin
               pend_d = prod_s;
               acc_d  = ACC_SET;
               cnt_d  = MULT_N;
            end
            OP_MULTU: begin
               pend_d = prod_u;
               acc_d  = ACC_SET;
               cnt_d  = MULT_N;
            end
            OP_DIV, OP_DIVU: begin
               pend_d = div_res;
               acc_d  = ACC_SET;
               cnt_d  = DIV_N;
            end
            OP_MTHI: hi_d = rs;
            OP_MTLO: lo_d = rs;
`ifdef MD_MADD_EN
            OP_MADD: begin
               pend_d = prod_s;
               acc_d  = ACC_ADD;
               cnt_d  = MULT_N;
            end
            OP_MSUB: begin
               pend_d = prod_s;
               acc_d  = ACC_SUB;
               cnt_d  = MULT_N;
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q   <= '0;
         lo_q   <= '0;
         cnt_q  <= '0;
         pend_q <= '0;
         acc_q  <= ACC_SET;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
         acc_q  <= acc_d;
      end
   end

endmodule
